// File: rtl/pc_pkg.sv
// pc_pkg: shared types and alignment helpers for the fetch-stage PC unit.
package pc_pkg;

  // Fetch state machine encoding.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Number of PC low bits forced to zero for a given instruction alignment.
  // 16-bit alignment (compressed) keeps bit 1; anything else is word aligned.
  function automatic int unsigned align_lsb(input int unsigned ialign);
    if (ialign == 32'd16) begin
      return 32'd1;
    end else begin
      return 32'd2;
    end
  endfunction

  // Sequential fetch step in bytes (2 or 4).
  function automatic int unsigned step_bytes(input int unsigned ialign);
    return 32'd1 << align_lsb(ialign);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority mux.
// Priority: trap > redirect > hold (HALT/BOOT/stall) > sequential advance.
// Reset is applied by the PC register itself in the top level.
// When PC_MISALIGN_TRAP_EN is defined, a misaligned redirect target that is
// not overridden by a trap is diverted to the trap vector and flagged.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  pc_state_e       state,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic [XLEN-1:0] pc_seq,
  output logic [XLEN-1:0] next_pc
);

  localparam int unsigned     STEP       = step_bytes(IALIGN);
  localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
  localparam logic [XLEN-1:0] LOW_MASK   = XLEN'(STEP - 32'd1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~LOW_MASK;

  logic hold_s;

  // Sequential address; wraps naturally modulo 2^XLEN.
  assign pc_seq = pc + STEP_X;

  // Anything other than RUN, or a stalled RUN, keeps the PC in place.
  assign hold_s = (state != RUN) || stall;

`ifdef PC_MISALIGN_TRAP_EN
  logic target_misaligned_s;

  assign target_misaligned_s = |(redirect_pc & LOW_MASK);

  // Priority select with misaligned redirects diverted to the trap vector.
  always_comb begin
    next_pc  = pc;
    misalign = 1'b0;
    if (trap_valid) begin
      next_pc = trap_pc & ALIGN_MASK;
    end else if (redirect_valid) begin
      if (target_misaligned_s) begin
        next_pc  = trap_pc & ALIGN_MASK;
        misalign = 1'b1;
      end else begin
        next_pc = redirect_pc & ALIGN_MASK;
      end
    end else if (hold_s) begin
      next_pc = pc;
    end else begin
      next_pc = pc_seq;
    end
  end
`else
  // Priority select; redirect targets simply have their low bits masked.
  always_comb begin
    next_pc = pc;
    if (trap_valid) begin
      next_pc = trap_pc & ALIGN_MASK;
    end else if (redirect_valid) begin
      next_pc = redirect_pc & ALIGN_MASK;
    end else if (hold_s) begin
      next_pc = pc;
    end else begin
      next_pc = pc_seq;
    end
  end
`endif

endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised fetch-stage program counter.
// Holds the fetch address, advances it sequentially, and accepts stall,
// redirect and trap requests plus debug halt/resume. Counts accepted fetches.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> trap).
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int unsigned     IALIGN       = 32,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [XLEN-1:0]   i_redirect_pc,
  input  logic              i_trap_valid,
  input  logic [XLEN-1:0]   i_trap_pc,
  input  logic              i_halt,
  input  logic              i_resume,
  output logic [XLEN-1:0]   o_pc,
  output logic              o_pc_valid,
  output logic [XLEN-1:0]   o_pc_seq,
  output logic              o_halted,
  output logic              o_misalign,
  output logic [XLEN-1:0]   o_misalign_addr,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  localparam int unsigned     STEP       = step_bytes(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(STEP - 32'd1);

  pc_state_e        state_r;
  logic             pc_valid_r;
  logic             halted_r;
  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [XLEN-1:0]  next_pc_s;
  logic [XLEN-1:0]  pc_seq_s;
  logic             fetch_fire_s;
`ifdef PC_MISALIGN_TRAP_EN
  logic             misalign_s;
`endif

  pc_next_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_sel (
    .pc             (pc_r),
    .state          (state_r),
    .stall          (i_stall),
    .redirect_valid (i_redirect_valid),
    .redirect_pc    (i_redirect_pc),
    .trap_valid     (i_trap_valid),
    .trap_pc        (i_trap_pc),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign       (misalign_s),
`endif
    .pc_seq         (pc_seq_s),
    .next_pc        (next_pc_s)
  );

  // A fetch is accepted when a valid PC is neither stalled nor replaced.
  assign fetch_fire_s = pc_valid_r && !i_stall && !i_trap_valid && !i_redirect_valid;

  // State machine with registered valid/halted decodes.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_r    <= BOOT;
      pc_valid_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          if (i_halt) begin
            state_r    <= HALT;
            pc_valid_r <= 1'b0;
            halted_r   <= 1'b1;
          end else begin
            state_r    <= RUN;
            pc_valid_r <= 1'b1;
            halted_r   <= 1'b0;
          end
        end
        RUN: begin
          if (i_halt) begin
            state_r    <= HALT;
            pc_valid_r <= 1'b0;
            halted_r   <= 1'b1;
          end else begin
            state_r    <= RUN;
            pc_valid_r <= 1'b1;
            halted_r   <= 1'b0;
          end
        end
        HALT: begin
          // A simultaneous halt request keeps the unit parked.
          if (i_resume && !i_halt) begin
            state_r    <= RUN;
            pc_valid_r <= 1'b1;
            halted_r   <= 1'b0;
          end else begin
            state_r    <= HALT;
            pc_valid_r <= 1'b0;
            halted_r   <= 1'b1;
          end
        end
        default: begin
          state_r    <= BOOT;
          pc_valid_r <= 1'b0;
          halted_r   <= 1'b0;
        end
      endcase
    end
  end

  // PC register: reset vector on reset, otherwise the selected next PC.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc_r <= RESET_VECTOR & ALIGN_MASK;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Accepted-fetch counter, wrapping at 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      fetch_cnt_r <= {CNT_W{1'b0}};
    end else if (fetch_fire_s) begin
      fetch_cnt_r <= fetch_cnt_r + CNT_W'(1);
    end else begin
      fetch_cnt_r <= fetch_cnt_r;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_r;
  logic [XLEN-1:0] misalign_addr_r;

  // Misalign pulse and sticky capture of the raw offending target.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      misalign_r      <= 1'b0;
      misalign_addr_r <= {XLEN{1'b0}};
    end else begin
      misalign_r <= misalign_s;
      if (misalign_s) begin
        misalign_addr_r <= i_redirect_pc;
      end else begin
        misalign_addr_r <= misalign_addr_r;
      end
    end
  end

  assign o_misalign      = misalign_r;
  assign o_misalign_addr = misalign_addr_r;
`else
  assign o_misalign      = 1'b0;
  assign o_misalign_addr = {XLEN{1'b0}};
`endif

  assign o_pc        = pc_r;
  assign o_pc_seq    = pc_seq_s;
  assign o_pc_valid  = pc_valid_r;
  assign o_halted    = halted_r;
  assign o_fetch_cnt = fetch_cnt_r;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage, replacing the fixed 32-bit word-aligned PC register. It holds the current fetch address and advances it sequentially. It accepts stall, branch/jump redirect and trap requests with fixed priority, and supports halt/resume for debug. It also detects misaligned redirect targets and counts accepted fetches.

## Interface
Parameters:
- XLEN, 32, address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 32, instruction alignment in bits: 32 means step 4 and 2 LSBs forced to zero; 16 means step 2 and 1 LSB forced to zero.
- CNT_W, 32, width of the fetch counter.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-low.
- i_stall  in  1  hold PC (downstream not ready).
- i_redirect_valid  in  1  branch/jump taken.
- i_redirect_pc  in  XLEN  redirect target.
- i_trap_valid  in  1  exception/interrupt entry.
- i_trap_pc  in  XLEN  trap vector.
- i_halt  in  1  debug halt request.
- i_resume  in  1  debug resume request.
- o_pc  out  XLEN  current fetch address (registered).
- o_pc_valid  out  1  o_pc is a fetch request this cycle.
- o_pc_seq  out  XLEN  o_pc + step (combinational, for link address).
- o_halted  out  1  unit is in HALT.
- o_misalign  out  1  one-cycle pulse: a redirect target was misaligned.
- o_misalign_addr  out  XLEN  offending target, held until the next misalign event.
- o_fetch_cnt  out  CNT_W  count of accepted fetches.

## Operation
- Step is 4 when IALIGN=32 and 2 when IALIGN=16. ALIGN_LSB is 2 or 1 respectively.
- All PC loads force the low ALIGN_LSB bits to zero.
- The state machine has three states:
  - BOOT: entered on reset. o_pc_valid=0. The PC holds RESET_VECTOR. Moves to RUN the next cycle unconditionally, unless i_halt is high, in which case it moves to HALT.
  - RUN: o_pc_valid=1. i_halt moves the unit to HALT at the next edge, and the PC is still updated by that cycle's selection.
  - HALT: o_pc_valid=0, o_halted=1. i_resume returns the unit to RUN. If i_halt and i_resume are both high, the unit stays in HALT.
- Next-PC priority, highest first:
  1. reset gives RESET_VECTOR.
  2. trap gives i_trap_pc.
  3. redirect gives i_redirect_pc.
  4. HALT, BOOT or i_stall hold the PC.
  5. Otherwise the PC advances to o_pc + step.
- Trap and redirect load the PC in every state, including HALT and during a stall. A load in HALT does not change state.
- Arithmetic wraps modulo 2^XLEN: the all-ones aligned address plus step gives 0.
- o_fetch_cnt increments when o_pc_valid && !i_stall && !i_trap_valid && !i_redirect_valid. It wraps at 2^CNT_W.

## Timing
- Reset values:
  - o_pc=RESET_VECTOR
  - state=BOOT
  - o_pc_valid=0
  - o_halted=0
  - o_misalign=0
  - o_misalign_addr=0
  - o_fetch_cnt=0
- Redirect and trap latency is 1 cycle: a request sampled at edge N appears on o_pc after edge N.
- o_pc_valid and o_halted are decoded from the registered state, with no combinational path from the inputs.
- o_pc_seq is combinational from o_pc only.
- If reset is asserted mid-stall or mid-halt, reset wins outright on the next edge.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect whose target has nonzero low ALIGN_LSB bits, and which is not overridden by a simultaneous trap, loads i_trap_pc instead of the target.
  - o_misalign pulses 1 cycle after the edge.
  - o_misalign_addr captures the raw target.
- PC_MISALIGN_TRAP_EN undefined:
  - Low bits are masked and the target is taken.
  - o_misalign is tied 0 and o_misalign_addr is tied 0.

## Structure
- Package pc_pkg holds:
  - the state enum pc_state_e (BOOT, RUN, HALT);
  - the function align_lsb(IALIGN);
  - the step constant derivation.
- One sub-module, pc_next_sel, is natural: a combinational priority mux producing the next PC and the misalign flag. The top level holds the state machine, the PC register and the counter.

## Test plan
- Reset low 2 cycles, then high, with RESET_VECTOR=32'h8000_0000. Required response:
  - o_pc=8000_0000 with valid=0 for 1 cycle;
  - then 8000_0000, 8000_0004, 8000_0008 with valid=1;
  - o_fetch_cnt increments by 1 per cycle.
- i_stall high 3 cycles at PC=0x10. Required response: PC stays 0x10, the counter freezes, then the PC advances to 0x14.
- Redirect to 0x200 and trap to 0x100 in the same cycle. Required response: next o_pc=0x100; the counter does not increment for that cycle.
- Halt at PC=0x40, then redirect to 0x80 while halted, then resume. Required response:
  - o_halted=1 and valid=0 while halted;
  - o_pc=0x80 while halted;
  - after resume, 0x80 then 0x84.
- Redirect to 0x102 with IALIGN=32. Required response:
  - with PC_MISALIGN_TRAP_EN: o_pc=i_trap_pc, o_misalign pulses once, o_misalign_addr=0x102;
  - without it: o_pc=0x100 and o_misalign=0.
- IALIGN=16, PC=FFFF_FFFE, no stall. Required response: next o_pc=0, and the redirect target 0x103 is taken as 0x102.
